usb_fs_rx_pkt_decoder: RTL

USB_FS_RX_PKT_DECODER -- requirements
Module: usb_fs_rx_pkt_decoder

---
 rtl/usb_fs_rx_pkt_decoder.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/usb_fs_rx_pkt_decoder.sv
// USB full-speed receive packet decoder: turns de-stuffed bytes from the bit layer
// into PID/token/SOF fields, a DATA payload stream, and a per-packet validity verdict.
module usb_fs_rx_pkt_decoder (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_sop,
   input  logic        in_byte_valid,
   input  logic [7:0]  in_byte,
   input  logic        in_eop,
   input  logic        in_err,
   output logic        rx_pkt_start,
   output logic        rx_pkt_end,
   output logic        rx_pkt_valid,
   output logic [3:0]  rx_pid,
   output logic [6:0]  rx_addr,
   output logic [3:0]  rx_endp,
   output logic [10:0] rx_frame_num,
   output logic        rx_data_put,
   output logic [7:0]  rx_data
);

   localparam logic [1:0] ST_IDLE     = 2'd0;
   localparam logic [1:0] ST_GET_PID  = 2'd1;
   localparam logic [1:0] ST_GET_BODY = 2'd2;
   localparam logic [1:0] ST_ABORT    = 2'd3;

   logic [1:0]  state_q, state_d;
   logic        pid_ok_q, pid_ok_d;
   logic        err_q, err_d;
   logic [10:0] cnt_q, cnt_d;
   logic [4:0]  crc5_q, crc5_d;
   logic [15:0] crc16_q, crc16_d;
   logic [3:0]  pid_q, pid_d;
   logic [6:0]  addr_q, addr_d;
   logic [3:0]  endp_q, endp_d;
   logic [10:0] frame_q, frame_d;
   logic        start_q, start_d;
   logic        end_q, end_d;
   logic        valid_q, valid_d;
   logic        put_q, put_d;
   logic [7:0]  data_q, data_d;

   // Bits enter LSB first; the register's MSB is the feedback tap.
   function automatic logic [4:0] crc5_byte(input logic [4:0] c, input logic [7:0] b);
      logic [4:0] r;
      r = c;
      for (int i = 0; i < 8; i++) begin
         if (r[4] ^ b[i]) r = {r[3:0], 1'b0} ^ 5'b00101;
         else             r = {r[3:0], 1'b0};
      end
      return r;
   endfunction

   function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] b);
      logic [15:0] r;
      r = c;
      for (int i = 0; i < 8; i++) begin
         if (r[15] ^ b[i]) r = {r[14:0], 1'b0} ^ 16'h8005;
         else              r = {r[14:0], 1'b0};
      end
      return r;
   endfunction

   function automatic logic pkt_ok(input logic ok, input logic err, input logic [1:0] kind,
                                   input logic [10:0] cnt, input logic [4:0] c5,
                                   input logic [15:0] c16);
      logic r;
      case (kind)
         2'b01:   r = (cnt == 11'd2) && (c5 == 5'b01100);
         2'b10:   r = (cnt == 11'd0);
         2'b11:   r = (cnt >= 11'd2) && (cnt <= 11'd1025) && (c16 == 16'h800D);
         default: r = 1'b0;
      endcase
      return r && ok && !err;
   endfunction

   // Next-state and output decode; the verdict uses the _d values so a byte
   // arriving together with EOP is already folded into length and CRC.
   always_comb begin
      state_d  = state_q;
      pid_ok_d = pid_ok_q;
      err_d    = err_q;
      cnt_d    = cnt_q;
      crc5_d   = crc5_q;
      crc16_d  = crc16_q;
      pid_d    = pid_q;
      addr_d   = addr_q;
      endp_d   = endp_q;
      frame_d  = frame_q;
      start_d  = 1'b0;
      end_d    = 1'b0;
      valid_d  = 1'b0;
      put_d    = 1'b0;
      data_d   = data_q;
      case (state_q)
         ST_IDLE: begin
            if (in_sop) begin
               state_d = ST_GET_PID;
               start_d = 1'b1;
               err_d   = 1'b0;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_GET_PID: begin
            err_d = err_q | in_err;
            if (in_sop) begin
               state_d = ST_ABORT;
               end_d   = 1'b1;
            end else if (in_byte_valid) begin
               pid_d    = in_byte[3:0];
               pid_ok_d = (in_byte[7:4] == ~in_byte[3:0]);
               cnt_d    = 11'd0;
               crc5_d   = 5'h1F;
               crc16_d  = 16'hFFFF;
               if (in_eop) begin
                  state_d = ST_IDLE;
                  end_d   = 1'b1;
                  valid_d = pkt_ok(pid_ok_d, err_d, pid_d[1:0], cnt_d, crc5_d, crc16_d);
               end else begin
                  state_d = ST_GET_BODY;
               end
            end else if (in_eop) begin
               state_d = ST_IDLE;
               end_d   = 1'b1;
            end else begin
               state_d = ST_GET_PID;
            end
         end
         ST_GET_BODY: begin
            err_d = err_q | in_err;
            if (in_sop) begin
               state_d = ST_ABORT;
               end_d   = 1'b1;
            end else begin
               if (in_byte_valid) begin
                  cnt_d   = (cnt_q == 11'd2047) ? cnt_q : cnt_q + 11'd1;
                  crc5_d  = crc5_byte(crc5_q, in_byte);
                  crc16_d = crc16_byte(crc16_q, in_byte);
                  if (pid_q[1:0] == 2'b01) begin
                     if (cnt_q == 11'd0) begin
                        addr_d        = in_byte[6:0];
                        endp_d[0]     = in_byte[7];
                        frame_d[7:0]  = in_byte;
                     end else if (cnt_q == 11'd1) begin
                        endp_d[3:1]   = in_byte[2:0];
                        frame_d[10:8] = in_byte[2:0];
                     end else begin
                        addr_d = addr_q;
                     end
                  end else if (pid_q[1:0] == 2'b11) begin
                     put_d  = 1'b1;
                     data_d = in_byte;
                  end else begin
                     put_d = 1'b0;
                  end
               end else begin
                  cnt_d = cnt_q;
               end
               if (in_eop) begin
                  state_d = ST_IDLE;
                  end_d   = 1'b1;
                  valid_d = pkt_ok(pid_ok_d, err_d, pid_d[1:0], cnt_d, crc5_d, crc16_d);
               end else begin
                  state_d = ST_GET_BODY;
               end
            end
         end
         ST_ABORT: begin
            state_d = ST_GET_PID;
            start_d = 1'b1;
            err_d   = 1'b0;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         pid_ok_q <= 1'b0;
         err_q    <= 1'b0;
         cnt_q    <= 11'd0;
         crc5_q   <= 5'h1F;
         crc16_q  <= 16'hFFFF;
         pid_q    <= 4'd0;
         addr_q   <= 7'd0;
         endp_q   <= 4'd0;
         frame_q  <= 11'd0;
         start_q  <= 1'b0;
         end_q    <= 1'b0;
         valid_q  <= 1'b0;
         put_q    <= 1'b0;
         data_q   <= 8'd0;
      end else begin
         state_q  <= state_d;
         pid_ok_q <= pid_ok_d;
         err_q    <= err_d;
         cnt_q    <= cnt_d;
         crc5_q   <= crc5_d;
         crc16_q  <= crc16_d;
         pid_q    <= pid_d;
         addr_q   <= addr_d;
         endp_q   <= endp_d;
         frame_q  <= frame_d;
         start_q  <= start_d;
         end_q    <= end_d;
         valid_q  <= valid_d;
         put_q    <= put_d;
         data_q   <= data_d;
      end
   end

   assign rx_pkt_start = start_q;
   assign rx_pkt_end   = end_q;
   assign rx_pkt_valid = valid_q;
   assign rx_pid       = pid_q;
   assign rx_addr      = addr_q;
   assign rx_endp      = endp_q;
   assign rx_frame_num = frame_q;
   assign rx_data_put  = put_q;
   assign rx_data      = data_q;

endmodule
